// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: two-master round-robin arbiter in front of a single shared
// Wishbone slave. A grant is held until the owning master drops cyc. A
// watchdog raises err to the granted master when the slave stalls too long.
module wb_rr_arbiter #(
   parameter int TIMEOUT = 255,  // stall limit in clk cycles, 0 = no watchdog
   parameter int ADR_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   // master 0
   input  logic [ADR_W-1:0] m0_adr_i,
   input  logic [31:0]      m0_dat_i,
   output logic [31:0]      m0_dat_o,
   input  logic [3:0]       m0_sel_i,
   input  logic             m0_we_i,
   input  logic             m0_cyc_i,
   input  logic             m0_stb_i,
   output logic             m0_ack_o,
   output logic             m0_err_o,
   // master 1
   input  logic [ADR_W-1:0] m1_adr_i,
   input  logic [31:0]      m1_dat_i,
   output logic [31:0]      m1_dat_o,
   input  logic [3:0]       m1_sel_i,
   input  logic             m1_we_i,
   input  logic             m1_cyc_i,
   input  logic             m1_stb_i,
   output logic             m1_ack_o,
   output logic             m1_err_o,
   // shared slave
   output logic [ADR_W-1:0] s_adr_o,
   output logic [31:0]      s_dat_o,
   output logic [3:0]       s_sel_o,
   output logic             s_we_o,
   output logic             s_cyc_o,
   output logic             s_stb_o,
   input  logic [31:0]      s_dat_i,
   input  logic             s_ack_i,
   // one-hot grant, 00 when idle
   output logic [1:0]       gnt_o
);

   // Counter is at least 8 bits, wider only when TIMEOUT needs it.
   localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic             last, last_nxt;      // last master served (1 = m1)
   logic [CNT_W-1:0] wd_cnt, wd_cnt_nxt;

   logic             mst_cyc, mst_stb;
   logic             timeout;
   logic             ack_ok;

   // State, last-served pointer and watchdog registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         last   <= 1'b1;                   // master 0 wins the first tie
         wd_cnt <= '0;
      end else begin
         state  <= state_nxt;
         last   <= last_nxt;
         wd_cnt <= wd_cnt_nxt;
      end
   end

   // Next-state: pick a master from IDLE, hold the grant until its cyc drops.
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) state_nxt = last ? GNT0 : GNT1;
            else if (m0_cyc_i)        state_nxt = GNT0;
            else if (m1_cyc_i)        state_nxt = GNT1;
         end
         GNT0: begin
            if (!m0_cyc_i) begin
               last_nxt  = 1'b0;
               state_nxt = m1_cyc_i ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (!m1_cyc_i) begin
               last_nxt  = 1'b1;
               state_nxt = m0_cyc_i ? GNT0 : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Slave-side request mux, watchdog kill and response steering.
   always_comb begin
      gnt_o   = {state == GNT1, state == GNT0};
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_we_o  = 1'b0;
      mst_cyc = 1'b0;
      mst_stb = 1'b0;
      if (state == GNT0) begin
         s_adr_o = m0_adr_i;
         s_dat_o = m0_dat_i;
         s_sel_o = m0_sel_i;
         s_we_o  = m0_we_i;
         mst_cyc = m0_cyc_i;
         mst_stb = m0_stb_i;
      end else if (state == GNT1) begin
         s_adr_o = m1_adr_i;
         s_dat_o = m1_dat_i;
         s_sel_o = m1_sel_i;
         s_we_o  = m1_we_i;
         mst_cyc = m1_cyc_i;
         mst_stb = m1_stb_i;
      end
      // A coincident ack beats the timeout.
      timeout  = (TIMEOUT != 0) && (state != IDLE) &&
                 (wd_cnt == CNT_W'(TIMEOUT)) && !s_ack_i;
      s_cyc_o  = mst_cyc;
      s_stb_o  = mst_stb && !timeout;
      // Acks outside an active strobe are dropped.
      ack_ok   = s_ack_i && s_stb_o;
      m0_ack_o = ack_ok && gnt_o[0];
      m1_ack_o = ack_ok && gnt_o[1];
      m0_err_o = timeout && gnt_o[0];
      m1_err_o = timeout && gnt_o[1];
      m0_dat_o = s_dat_i;
      m1_dat_o = s_dat_i;
   end

   // Watchdog: count stalled strobe cycles, restart on ack, timeout or regrant.
   always_comb begin
      wd_cnt_nxt = wd_cnt;
      if (state == IDLE || state_nxt != state || s_ack_i || timeout)
         wd_cnt_nxt = '0;
      else if (s_stb_o)
         wd_cnt_nxt = wd_cnt + 1'b1;
   end

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: bus-cycle watchdog limit in clk cycles; 0 disables the watchdog.
REQ-002 Parameter ADR_W, default 32: address width.
REQ-003 clk  in  1  system clock; single clock domain.
REQ-004 rst  in  1  reset, asynchronous assert, active-low.
REQ-005 mN_adr_i (N=0,1)  in  ADR_W  master N address.
REQ-006 mN_dat_i  in  32  master N write data.
REQ-007 mN_dat_o  out  32  read data to master N.
REQ-008 mN_sel_i  in  4  master N byte select.
REQ-009 mN_we_i  in  1  master N write enable.
REQ-010 mN_cyc_i  in  1  master N cycle request.
REQ-011 mN_stb_i  in  1  master N strobe.
REQ-012 mN_ack_o  out  1  acknowledge to master N.
REQ-013 mN_err_o  out  1  watchdog error to master N.
REQ-014 s_adr_o / s_dat_o / s_sel_o / s_we_o  out  ADR_W/32/4/1  shared-slave request fields.
REQ-015 s_cyc_o / s_stb_o  out  1  shared-slave cycle and strobe.
REQ-016 s_dat_i / s_ack_i  in  32/1  shared-slave read data and acknowledge.
REQ-017 gnt_o  out  2  one-hot current grant; 2'b00 when idle.

Function
REQ-018 FSM states IDLE, GNT0, GNT1; state, grant, last-served pointer and watchdog counter are registers.
REQ-019 IDLE: m0_cyc_i only -> GNT0; m1_cyc_i only -> GNT1; both -> the master not last served; neither -> stay IDLE.
REQ-020 Grant latency: exactly one clk from cyc assertion in IDLE to gnt_o/s_cyc_o assertion.
REQ-021 GNTn: held while mN_cyc_i high; no preemption regardless of other master.
REQ-022 GNTn with mN_cyc_i low: next state GNT(other) if other cyc high, else IDLE; pointer updates to N.
REQ-023 s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o: combinational mux of granted master; all zero in IDLE.
REQ-024 s_cyc_o = granted master's cyc_i AND grant active; never asserted in IDLE.
REQ-025 mN_ack_o = s_ack_i AND gnt_o[N]; non-granted master ack/err always 0.
REQ-026 mN_dat_o = s_dat_i for both masters (broadcast); only the ack qualifies it.
REQ-027 Watchdog: 8+ bit counter increments each clk with s_stb_o high and s_ack_i low; clears on s_ack_i, on grant change, in IDLE.
REQ-028 Counter reaching TIMEOUT: mN_err_o pulses one clk for granted N, s_stb_o forced low that clk, counter clears; grant retained.
REQ-029 s_ack_i and timeout in the same clk: ack wins, no err.
REQ-030 s_ack_i while IDLE or granted stb low: ignored, no ack forwarded.

Reset
REQ-031 rst low: immediately state IDLE, gnt_o 2'b00, all s_* outputs 0, ack/err 0, counter 0, pointer = master 1 (master 0 wins first tie).
REQ-032 rst low mid-transfer: transfer aborted, no ack/err generated; first grant after release follows REQ-019 with 1-clk latency.

Verification
REQ-033 After reset, m0_cyc/m1_cyc raised same clk -> gnt_o=01 next clk; m0 drops -> gnt_o=10 following clk, no IDLE gap.
REQ-034 Alternating ties: both masters re-request continuously, single-beat each -> grants 01,10,01,10; no master served twice consecutively.
REQ-035 m1 granted, read addr 0x40000004, slave returns 0xDEADBEEF with ack after 3 clks -> m1_ack_o one clk, m1_dat_o=0xDEADBEEF, m0_ack_o stays 0.
REQ-036 TIMEOUT=4, slave never acks -> err to granted master after 4 stb clks, s_stb_o low that clk, counter restarts; TIMEOUT=0 -> no err ever.
REQ-037 Ack and timeout coincide at count 4 -> ack only, err stays 0.
REQ-038 rst pulsed low mid-transfer with m0 granted -> gnt_o=00 asynchronously, no ack/err; after release with m1_cyc high -> gnt_o=10 one clk later.
